sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO that combines storage, binary wrap-bit pointers, and status generation in one block. It is the single-clock successor to the async FIFO storage array. It adds:
- registered or first-word-fall-through (FWFT) read modes,
- occupancy count,
- programmable almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags.

It is used wherever producer and consumer share a clock and no CDC is needed.

---
 rtl/sync_fifo_ctrl.sv | 93 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage, wrap-bit binary pointers, occupancy and status flags.
// Supports registered (FWFT=0) or first-word-fall-through (FWFT=1) read data.
module sync_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PTR_WIDTH  = 5,
   parameter int unsigned AF_LEVEL   = 28,
   parameter int unsigned AE_LEVEL   = 4,
   parameter bit          FWFT       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned       DEPTH   = 1 << PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] AF_THR = AF_LEVEL[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AE_THR = AE_LEVEL[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH:0]    b_wptr;
   logic [PTR_WIDTH:0]    b_rptr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Status decodes only from registered pointers, so it never glitches on inputs.
   assign full  = (b_wptr[PTR_WIDTH] != b_rptr[PTR_WIDTH]) &&
                  (b_wptr[PTR_WIDTH-1:0] == b_rptr[PTR_WIDTH-1:0]);
   assign empty = (b_wptr == b_rptr);
   assign count = b_wptr - b_rptr;
   assign almost_full  = (count >= AF_THR);
   assign almost_empty = (count <= AE_THR);

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_wptr    <= '0;
         b_rptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) b_wptr <= b_wptr + PTR_ONE;
         if (rd_ok) b_rptr <= b_rptr + PTR_ONE;
         // A fresh error in the same cycle as err_clr keeps the flag set.
         if (wr_en & full)    overflow <= 1'b1;
         else if (err_clr)    overflow <= 1'b0;
         if (rd_en & empty)   underflow <= 1'b1;
         else if (err_clr)    underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[b_wptr[PTR_WIDTH-1:0]] <= data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out   = mem[b_rptr[PTR_WIDTH-1:0]];
         assign data_valid = ~empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] data_q;
         logic                  valid_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_ok;
               if (rd_ok) data_q <= mem[b_rptr[PTR_WIDTH-1:0]];
            end
         end

         assign data_out   = data_q;
         assign data_valid = valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: a registered-read instance checked through a
// read-data queue, plus a fall-through instance checked directly.
module tb_sync_fifo_ctrl;

   logic        clk;
   logic        rst;
   logic        wr0, rd0, clr0;
   logic [31:0] din0;
   logic [31:0] dout0;
   logic        dv0, full0, empty0, af0, ae0, ovf0, udf0;
   logic [5:0]  cnt0;

   logic        wr1, rd1, clr1;
   logic [31:0] din1;
   logic [31:0] dout1;
   logic        dv1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [5:0]  cnt1;

   int total = 0;
   int bad   = 0;

   logic [31:0] model[$];
   logic [31:0] exp_q[$];

   sync_fifo_ctrl #(.DATA_WIDTH(32), .PTR_WIDTH(5), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr0), .data_in(din0), .rd_en(rd0), .err_clr(clr0),
      .data_out(dout0), .data_valid(dv0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo_ctrl #(.DATA_WIDTH(32), .PTR_WIDTH(5), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr1), .data_in(din1), .rd_en(rd1), .err_clr(clr1),
      .data_out(dout1), .data_valid(dv1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every registered-read output word must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && dv0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got %0h, required no output", dout0);
         end else begin
            chk("rd_data", {32'h0, dout0}, {32'h0, exp_q.pop_front()});
         end
      end
   end

   // One clock on dut0; the model decides acceptance from the pre-edge occupancy.
   task automatic op0(input logic w, input logic [31:0] d, input logic r, input logic c);
      int n;
      n    = model.size();
      wr0  = w;
      din0 = d;
      rd0  = r;
      clr0 = c;
      if (r && n != 0) exp_q.push_back(model.pop_front());
      if (w && n != 32) model.push_back(d);
      @(posedge clk);
      #1;
      wr0  = 1'b0;
      rd0  = 1'b0;
      clr0 = 1'b0;
   endtask

   task automatic op1(input logic w, input logic [31:0] d, input logic r, input logic c);
      wr1  = w;
      din1 = d;
      rd1  = r;
      clr1 = c;
      @(posedge clk);
      #1;
      wr1  = 1'b0;
      rd1  = 1'b0;
      clr1 = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_empty"}, {63'h0, empty0}, 64'd1);
      chk({tag, "_ae"},    {63'h0, ae0},    64'd1);
      chk({tag, "_full"},  {63'h0, full0},  64'd0);
      chk({tag, "_af"},    {63'h0, af0},    64'd0);
      chk({tag, "_count"}, {58'h0, cnt0},   64'd0);
      chk({tag, "_dout"},  {32'h0, dout0},  64'd0);
      chk({tag, "_dv"},    {63'h0, dv0},    64'd0);
      chk({tag, "_ovf"},   {63'h0, ovf0},   64'd0);
      chk({tag, "_udf"},   {63'h0, udf0},   64'd0);
   endtask

   initial begin
      int step;
      logic [31:0] wd;
      rst = 1'b1;
      wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; din0 = '0;
      wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0; din1 = '0;
      #1;
      chk_reset_state("por");
      chk("por_dv1", {63'h0, dv1}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset mid-stream with 10 words stored, no clock edge needed.
      for (int i = 0; i < 10; i++) op0(1'b1, 32'h100 + i, 1'b0, 1'b0);
      chk("ten_count", {58'h0, cnt0}, 64'd10);
      rst = 1'b1;
      #1;
      chk_reset_state("midrst");
      model.delete();
      #1;
      rst = 1'b0;
      op0(1'b1, 32'h55, 1'b0, 1'b0);
      op0(1'b0, 32'h0, 1'b1, 1'b0);
      op0(1'b0, 32'h0, 1'b0, 1'b0);

      // Fill 0..31, almost_full rises at count 28.
      for (int i = 0; i < 32; i++) begin
         op0(1'b1, i, 1'b0, 1'b0);
         chk("fill_af", {63'h0, af0}, (i + 1 >= 28) ? 64'd1 : 64'd0);
      end
      chk("fill_full", {63'h0, full0}, 64'd1);
      chk("fill_count", {58'h0, cnt0}, 64'd32);
      op0(1'b1, 32'hDEAD, 1'b0, 1'b0);
      chk("ovf_set", {63'h0, ovf0}, 64'd1);
      chk("ovf_count", {58'h0, cnt0}, 64'd32);

      // Drain in order, then one read past empty.
      for (int i = 0; i < 32; i++) op0(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_empty", {63'h0, empty0}, 64'd1);
      op0(1'b0, 32'h0, 1'b0, 1'b1);
      chk("clr_ovf", {63'h0, ovf0}, 64'd0);
      op0(1'b0, 32'h0, 1'b1, 1'b0);
      chk("udf_set", {63'h0, udf0}, 64'd1);
      chk("udf_dv", {63'h0, dv0}, 64'd0);
      op0(1'b0, 32'h0, 1'b0, 1'b1);

      // Wrap-around: occupancy walks 5,6,7,6,5,4,3,4,5 repeatedly.
      wd = 32'h1000;
      for (int i = 0; i < 5; i++) begin
         op0(1'b1, wd, 1'b0, 1'b0);
         wd++;
      end
      step = 0;
      for (int k = 0; k < 25; k++) begin
         for (int j = 0; j < 8; j++) begin
            if (j < 2 || j >= 6) begin
               op0(1'b1, wd, 1'b0, 1'b0);
               wd++;
            end else begin
               op0(1'b0, 32'h0, 1'b1, 1'b0);
            end
            chk("wrap_count", {58'h0, cnt0}, 64'(model.size()));
            chk("wrap_ae", {63'h0, ae0}, (model.size() <= 4) ? 64'd1 : 64'd0);
            step++;
         end
      end
      for (int i = 0; i < 5; i++) op0(1'b0, 32'h0, 1'b1, 1'b0);

      // Simultaneous read and write at empty, count 5 and full.
      op0(1'b1, 32'h2000, 1'b1, 1'b0);
      chk("sim_empty_count", {58'h0, cnt0}, 64'd1);
      chk("sim_empty_udf", {63'h0, udf0}, 64'd1);
      for (int i = 1; i < 5; i++) op0(1'b1, 32'h2000 + i, 1'b0, 1'b1);
      chk("sim5_pre", {58'h0, cnt0}, 64'd5);
      op0(1'b1, 32'h2005, 1'b1, 1'b0);
      chk("sim5_count", {58'h0, cnt0}, 64'd5);
      for (int i = 0; i < 27; i++) op0(1'b1, 32'h3000 + i, 1'b0, 1'b0);
      chk("simfull_pre", {63'h0, full0}, 64'd1);
      op0(1'b1, 32'hBEEF, 1'b1, 1'b0);
      chk("simfull_count", {58'h0, cnt0}, 64'd31);
      chk("simfull_ovf", {63'h0, ovf0}, 64'd1);
      for (int i = 0; i < 31; i++) op0(1'b0, 32'h0, 1'b1, 1'b0);
      op0(1'b0, 32'h0, 1'b0, 1'b0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      // Fall-through instance.
      op1(1'b1, 32'hA5, 1'b0, 1'b0);
      chk("fwft_dout", {32'h0, dout1}, 64'hA5);
      chk("fwft_dv", {63'h0, dv1}, 64'd1);
      op1(1'b1, 32'h5A, 1'b0, 1'b0);
      chk("fwft_head_hold", {32'h0, dout1}, 64'hA5);
      op1(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fwft_next_head", {32'h0, dout1}, 64'h5A);
      op1(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fwft_dv_empty", {63'h0, dv1}, 64'd0);
      op1(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fwft_udf", {63'h0, udf1}, 64'd1);
      op1(1'b0, 32'h0, 1'b1, 1'b1);
      chk("fwft_set_dominates", {63'h0, udf1}, 64'd1);
      op1(1'b0, 32'h0, 1'b0, 1'b1);
      chk("fwft_clr", {63'h0, udf1}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
